// File: rtl/calc_display_scan.sv
// calc_display_scan: converts a binary value to blanked BCD digits with a
// sequential double-dabble engine, holds them in a display buffer and
// continuously scans that buffer onto the data/pos digit bus.
module calc_display_scan #(
  parameter int WIDTH    = 27,
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  input  logic             err_in,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       data,
  output logic [3:0]       pos
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  // Largest value that fits in eight decimal digits.
  localparam logic [63:0] MAX_SHOW = 64'd99_999_999;

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shift;
  logic [BCD_W-1:0] bcd;
  logic [CNT_W-1:0] iter;
  logic [3:0]       buffer [DIGITS];
  logic [IDX_W-1:0] idx;
  logic [DIV_W-1:0] div;

  logic             too_big;
  logic             take_err;
  logic             take_value;
  logic             last_iter;
  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W-1:0] bcd_step;
  logic [3:0]       blanked [DIGITS];

  assign too_big = 64'(value) > MAX_SHOW;
  assign busy    = (state == CONVERT);

  // Double-dabble correction: every nibble of 5 or more gets +3 before the shift.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd[4*gi +: 4] >= 4'd5) ? bcd[4*gi +: 4] + 4'd3
                                                           : bcd[4*gi +: 4];
    end
  endgenerate

  // One iteration: shift the corrected BCD left, pulling in the next binary MSB.
  assign bcd_step = {bcd_adj[BCD_W-2:0], shift[WIDTH-1]};

  // Leading-zero blanking of the final result; digit 0 is always shown.
  always_comb begin : blank_proc
    logic lead;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (i != 0 && lead && bcd_step[4*i +: 4] == 4'd0) begin
        blanked[i] = 4'hF;
      end else begin
        blanked[i] = bcd_step[4*i +: 4];
        lead       = 1'b0;
      end
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and per-cycle control decodes; loads outside IDLE are dropped.
  always_comb begin
    state_next = state;
    take_err   = 1'b0;
    take_value = 1'b0;
    last_iter  = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          if (err_in || too_big) begin
            take_err = 1'b1;
          end else begin
            take_value = 1'b1;
            state_next = CONVERT;
          end
        end
      end
      CONVERT: begin
        if (iter == CNT_W'(WIDTH - 1)) begin
          last_iter  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Conversion datapath plus the done/ovf status flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift <= '0;
      bcd   <= '0;
      iter  <= '0;
      done  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= take_err | last_iter;
      if (take_err) begin
        ovf <= too_big && !err_in;
      end else if (take_value) begin
        shift <= value;
        bcd   <= '0;
        iter  <= '0;
        ovf   <= 1'b0;
      end else if (state == CONVERT) begin
        shift <= shift << 1;
        bcd   <= bcd_step;
        iter  <= iter + CNT_W'(1);
      end
    end
  end

  // Display buffer: only rewritten on an error load or on the final iteration.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DIGITS; i++) buffer[i] <= (i == 0) ? 4'h0 : 4'hF;
    end else if (take_err) begin
      for (int i = 0; i < DIGITS; i++) buffer[i] <= (i == 0) ? 4'hE : 4'hF;
    end else if (last_iter) begin
      for (int i = 0; i < DIGITS; i++) buffer[i] <= blanked[i];
    end
  end

  // Free-running scan: every SCAN_DIV clocks present the next buffer digit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div  <= '0;
      idx  <= '0;
      data <= 4'h0;
      pos  <= 4'h0;
    end else if (div == DIV_W'(SCAN_DIV - 1)) begin
      div  <= '0;
      data <= buffer[idx];
      pos  <= 4'(idx);
      idx  <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      div <= div + DIV_W'(1);
    end
  end

endmodule

// File: tb/tb_calc_display_scan.sv
// Self-checking bench for calc_display_scan: two instances (SCAN_DIV 1 and 3)
// share stimulus; a decimal-arithmetic model predicts the displayed digits.
module tb_calc_display_scan;

  localparam int WIDTH = 27;

  logic             clock  = 1'b0;
  logic             reset  = 1'b1;
  logic             load   = 1'b0;
  logic             err_in = 1'b0;
  logic [WIDTH-1:0] value  = '0;

  logic       busy1, done1, ovf1;
  logic [3:0] data1, pos1;
  logic       busy3, done3, ovf3;
  logic [3:0] data3, pos3;

  int vectors     = 0;
  int miscompares = 0;

  logic [3:0] model_buf [8];
  logic [3:0] old_buf   [8];

  always #5 clock = ~clock;

  calc_display_scan #(.WIDTH(WIDTH), .DIGITS(8), .SCAN_DIV(1)) dut1 (
    .clock(clock), .reset(reset), .load(load), .value(value), .err_in(err_in),
    .busy(busy1), .done(done1), .ovf(ovf1), .data(data1), .pos(pos1)
  );

  calc_display_scan #(.WIDTH(WIDTH), .DIGITS(8), .SCAN_DIV(3)) dut3 (
    .clock(clock), .reset(reset), .load(load), .value(value), .err_in(err_in),
    .busy(busy3), .done(done3), .ovf(ovf3), .data(data3), .pos(pos3)
  );

  // Expected display contents from decimal arithmetic.
  task automatic model_set(input longint v, input bit e);
    longint p;
    if (e || v > 99_999_999) begin
      for (int i = 0; i < 8; i++) model_buf[i] = (i == 0) ? 4'hE : 4'hF;
    end else begin
      p = 1;
      for (int i = 0; i < 8; i++) begin
        if (i == 0 || v >= p) model_buf[i] = 4'((v / p) % 10);
        else                  model_buf[i] = 4'hF;
        p = p * 10;
      end
    end
  endtask

  // Called at the negedge where reset was released: check scan phase of both DUTs.
  task automatic scan_after_release(input string tag);
    int steps3, ep1, ep3;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      ep1    = k % 8;
      steps3 = (k + 1) / 3;
      ep3    = (steps3 == 0) ? 0 : (steps3 - 1) % 8;
      vectors++;
      if (pos1 !== 4'(ep1) || data1 !== model_buf[ep1]) begin
        miscompares++;
        $display("FAIL %s scan1 k=%0d: got pos=%0d data=%h, want pos=%0d data=%h",
                 tag, k, pos1, data1, ep1, model_buf[ep1]);
      end
      vectors++;
      if (pos3 !== 4'(ep3) || data3 !== model_buf[ep3]) begin
        miscompares++;
        $display("FAIL %s scan3 k=%0d: got pos=%0d data=%h, want pos=%0d data=%h",
                 tag, k, pos3, data3, ep3, model_buf[ep3]);
      end
      vectors++;
      if (busy1 !== 1'b0 || done1 !== 1'b0 || ovf1 !== 1'b0) begin
        miscompares++;
        $display("FAIL %s flags k=%0d: got busy=%b done=%b ovf=%b, want 0 0 0",
                 tag, k, busy1, done1, ovf1);
      end
    end
    $display("%s: 30-cycle scan after reset checked", tag);
  endtask

  // One load transaction, optionally with a second load injected at E0+drop_at.
  task automatic apply_load(input logic [WIDTH-1:0] v, input bit e, input int drop_at,
                            input logic [WIDTH-1:0] drop_v, input string tag);
    int s, busy_n, done_at, exp_done_at, prev;
    bit bad, exp_ovf;
    old_buf     = model_buf;
    exp_ovf     = (longint'(v) > 99_999_999) && !e;
    bad         = e || (longint'(v) > 99_999_999);
    exp_done_at = bad ? 0 : WIDTH;
    prev        = 0;
    @(negedge clock);
    load = 1'b1; value = v; err_in = e;
    @(negedge clock);
    s = 0; busy_n = 0; done_at = -1;
    while (done_at < 0 && s < WIDTH + 10) begin
      load   = (drop_at != 0 && s + 1 == drop_at);
      value  = drop_v;
      err_in = 1'b0;
      if (busy1 === 1'b1) busy_n++;
      if (done1 === 1'b1) done_at = s;
      vectors++;
      if (data1 !== old_buf[pos1[2:0]]) begin
        miscompares++;
        $display("FAIL %s old_display s=%0d pos=%0d: got %h, want %h",
                 tag, s, pos1, data1, old_buf[pos1[2:0]]);
      end
      @(negedge clock);
      s++;
    end
    load = 1'b0;
    vectors++;
    if (done_at != exp_done_at) begin
      miscompares++;
      $display("FAIL %s done_latency: got %0d, want %0d", tag, done_at, exp_done_at);
    end
    vectors++;
    if (busy_n != (bad ? 0 : WIDTH)) begin
      miscompares++;
      $display("FAIL %s busy_cycles: got %0d, want %0d", tag, busy_n, bad ? 0 : WIDTH);
    end
    vectors++;
    if (ovf1 !== exp_ovf) begin
      miscompares++;
      $display("FAIL %s ovf: got %b, want %b", tag, ovf1, exp_ovf);
    end
    model_set(longint'(v), e);
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (data1 !== model_buf[pos1[2:0]] || busy1 !== 1'b0 || done1 !== 1'b0 ||
          (k > 0 && pos1 !== 4'((prev + 1) % 8))) begin
        miscompares++;
        $display("FAIL %s new_display k=%0d: got pos=%0d data=%h busy=%b done=%b, want data=%h busy=0 done=0 pos=%0d",
                 tag, k, pos1, data1, busy1, done1, model_buf[pos1[2:0]], (prev + 1) % 8);
      end
      prev = int'(pos1);
      @(negedge clock);
    end
    $display("%s: value=%0d err=%0b busy_cycles=%0d done_at=%0d ovf=%0b",
             tag, v, e, busy_n, done_at, ovf1);
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0;
    repeat (3) @(negedge clock);
    vectors++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || ovf1 !== 1'b0 || data1 !== 4'h0 ||
        pos1 !== 4'h0 || pos3 !== 4'h0 || data3 !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_values: got busy=%b done=%b ovf=%b data=%h pos=%0d pos3=%0d data3=%h, want all 0",
               busy1, done1, ovf1, data1, pos1, pos3, data3);
    end
    model_set(0, 1'b0);
    reset = 1'b0;
    scan_after_release("reset");
  endtask

  task automatic test_basic();
    apply_load(WIDTH'(12345), 1'b0, 0, '0, "basic_12345");
  endtask

  task automatic test_limits();
    apply_load(WIDTH'(99_999_999), 1'b0, 0, '0, "max_99999999");
    apply_load(WIDTH'(100_000_000), 1'b0, 0, '0, "ovf_100000000");
  endtask

  task automatic test_back_to_back();
    apply_load(WIDTH'(42), 1'b0, 5, WIDTH'(7), "drop_at_5");
    apply_load(WIDTH'(5), 1'b0, WIDTH, WIDTH'(123), "drop_at_last");
  endtask

  task automatic test_err();
    apply_load(WIDTH'(7), 1'b1, 0, '0, "err_7");
    apply_load(WIDTH'(0), 1'b0, 0, '0, "zero");
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] v;
    bit e;
    int r;
    for (int n = 0; n < 8; n++) begin
      r = int'($urandom_range(0, 3));
      if (r == 0)      v = WIDTH'($urandom_range(100_000_000, 134_217_727));
      else if (r == 1) v = WIDTH'($urandom_range(0, 999));
      else             v = WIDTH'($urandom_range(0, 99_999_999));
      e = ($urandom_range(0, 7) == 0);
      apply_load(v, e, 0, '0, "random");
    end
  endtask

  task automatic test_scan_div3();
    int prev, run, changes;
    prev = int'(pos3); run = 0; changes = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      vectors++;
      if (data3 !== model_buf[pos3[2:0]]) begin
        miscompares++;
        $display("FAIL scan3_data pos=%0d: got %h, want %h", pos3, data3, model_buf[pos3[2:0]]);
      end
      if (int'(pos3) != prev) begin
        vectors++;
        if (pos3 !== 4'((prev + 1) % 8)) begin
          miscompares++;
          $display("FAIL scan3_order: got pos=%0d, want %0d", pos3, (prev + 1) % 8);
        end
        if (changes > 0) begin
          vectors++;
          if (run != 3) begin
            miscompares++;
            $display("FAIL scan3_period: got %0d clocks, want 3", run);
          end
        end
        changes++; run = 1; prev = int'(pos3);
      end else begin
        run++;
      end
    end
    vectors++;
    if (changes < 12) begin
      miscompares++;
      $display("FAIL scan3_steps: got %0d position changes in 40 clocks, want >= 12", changes);
    end
    $display("scan_div3: %0d position changes in 40 clocks", changes);
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    load = 1'b1; value = WIDTH'(12_345_678); err_in = 1'b0;
    @(negedge clock);
    load = 1'b0;
    repeat (9) @(negedge clock);
    vectors++;
    if (busy1 !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_busy_before: got %b, want 1", busy1);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || data1 !== 4'h0 || pos1 !== 4'h0 ||
        pos3 !== 4'h0 || data3 !== 4'h0 || busy3 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_async: got busy=%b done=%b data=%h pos=%0d pos3=%0d data3=%h busy3=%b, want 0",
               busy1, done1, data1, pos1, pos3, data3, busy3);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_set(0, 1'b0);
    scan_after_release("reset_mid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_limits();
    test_back_to_back();
    test_err();
    test_random();
    test_scan_div3();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/calc_display_scan.md
Name: calc_display_scan

Overview:
- Downstream display stage of the calculator. Accepts a binary result or operand value plus an error flag from the calculator FSM.
- Converts the value to 8 BCD digits with a sequential double-dabble engine and stores them in a display buffer.
- Continuously time-multiplexes the buffer onto the data/pos digit bus that feeds the 7-segment driver.
- Scanning always reads the stable buffer, so a conversion in progress never tears the displayed value.

Parameters:
- WIDTH, 27, width of the binary input value.
- DIGITS, 8, number of display digits (pos range 0..DIGITS-1).
- SCAN_DIV, 1, clocks per digit step of the scan (must be >= 1).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  single-cycle request to display value/err_in.
- value  input  WIDTH  unsigned binary number to display.
- err_in  input  1  show the error pattern instead of value (sampled with load).
- busy  output  1  conversion in progress; load ignored while high.
- done  output  1  one-cycle pulse when the buffer has been updated.
- ovf  output  1  last accepted value exceeded 99_999_999.
- data  output  4  digit code for the current pos (0-9 digit, 4'hE = 'E', 4'hF = blank).
- pos  output  4  digit position, 0 = least significant (rightmost).

Behaviour:
- Reset is asynchronous, active-high, clock is clock.
- Reset values:
  - busy=0, done=0, ovf=0, data=0, pos=0.
  - Scan index and divider = 0.
  - Buffer: digit0 = 0, digits 1..7 = 4'hF (shows "0").
- Reset asserted mid-conversion aborts it. The buffer returns to its reset contents and no done pulse is issued.
- States: IDLE, CONVERT.
- IDLE, load=1, sampled at edge E0:
  - If err_in=1 or value > 99_999_999, then at E0: buffer = digit0 4'hE, digits 1..7 4'hF. ovf = (value > 99_999_999) and !err_in. done pulses for 1 cycle. State stays IDLE and busy never rises.
  - Otherwise: capture value into the shift register, clear the 32-bit BCD register and iteration counter, set ovf=0 and busy=1, and go to CONVERT.
- CONVERT, one double-dabble iteration per clock:
  - Each BCD nibble >= 5 gets +3, then {bcd, shift} shifts left by 1.
  - At the edge completing iteration WIDTH (E0+WIDTH): write the blanked result to the buffer, set busy=0, pulse done for the following cycle, and return to IDLE.
  - Total latency from load to buffer update is WIDTH clocks.
- Leading-zero blanking applies when the buffer is written. Nibbles above the most significant nonzero digit become 4'hF. Digit0 is always shown, so value 0 shows "0".
- A load while busy=1 is dropped, with no queueing. A load in the same cycle as the final iteration is also dropped, because busy is still high.
- The buffer is unchanged during CONVERT, so the scan keeps showing the previous value.
- Scan:
  - A divider counts 0..SCAN_DIV-1. On the edge where it equals SCAN_DIV-1, register data = buffer[idx] and pos = idx, and set idx = idx+1, wrapping DIGITS-1 -> 0.
  - The scan runs every cycle regardless of state or load.
  - When the buffer changes, new digits appear starting from the current idx, with no restart.
- data/pos are registered and change together, so they are never a mismatched pair.

Test Plan:
- Reset, SCAN_DIV=1 -> consecutive cycles give (pos,data) = (0,0),(1,F),(2,F)...(7,F),(0,0); busy=0, ovf=0.
- load value=12345 -> busy high exactly 27 cycles, done 1 cycle. Scan then gives pos0..7 = 5,4,3,2,1,F,F,F. During busy, the scan still shows the prior buffer.
- load 99_999_999 -> all eight digits 9, ovf=0. Then load 100_000_000 -> ovf=1, busy never high, done next cycle, display pos0=E, rest F.
- load 42, then load 7 while busy at cycle +5 -> the second load is ignored and the display shows 2,4,F... Also check load at the final-iteration cycle is dropped.
- load value=7 with err_in=1 -> ovf=0, display E,F,F,F,F,F,F,F. Then load 0 -> display 0,F,...,F.
- SCAN_DIV=3 -> pos advances every 3 clocks and wraps 7->0. Asserting reset at conversion cycle 10 -> busy=0, no done, display "0", pos=0 immediately.
